// File: rtl/instruction_fetch.sv
// Instruction fetch stage: reads four bytes per instruction from a byte-wide memory,
// assembles them big-endian and hands the word to decode over valid/ready.
module instruction_fetch #(
    parameter int unsigned          ADDR_W   = 10,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_wr,
    input  logic [7:0]        imem_data,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target
);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [23:0]       bytes_q, bytes_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;

    assign imem_wr     = 1'b0;
    assign imem_addr   = (state_q == FETCH) ? pc_q + ADDR_W'(cnt_q) : pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        bytes_d    = bytes_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;

        // Redirect overrides both the final-byte capture and a same-cycle handshake.
        if (branch_en) begin
            pc_d    = branch_target & ~ADDR_W'(3);
            cnt_d   = 2'd0;
            valid_d = 1'b0;
            state_d = FETCH;
        end else begin
            unique case (state_q)
                FETCH: begin
                    cnt_d = cnt_q + 2'd1;
                    unique case (cnt_q)
                        2'd0: bytes_d[23:16] = imem_data;
                        2'd1: bytes_d[15:8]  = imem_data;
                        2'd2: bytes_d[7:0]   = imem_data;
                        2'd3: begin
                            instr_d    = {bytes_q, imem_data};
                            instr_pc_d = pc_q;
                            valid_d    = 1'b1;
                            state_d    = HOLD;
                        end
                        default: ;
                    endcase
                end
                HOLD: begin
                    if (valid_q && instr_ready) begin
                        pc_d    = pc_q + ADDR_W'(4);
                        cnt_d   = 2'd0;
                        valid_d = 1'b0;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            cnt_q      <= 2'd0;
            bytes_q    <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            bytes_q    <= bytes_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run
// compared cycle by cycle against a transaction-level model of the fetch stage.
module tb_instruction_fetch;

    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_wr;
    logic [7:0]        imem_data;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_target;

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    // Reference model: current word address, bytes fetched so far, and presented word.
    logic [ADDR_W-1:0] m_pc;
    int                m_got;
    logic              m_valid;
    logic [31:0]       m_instr;
    logic [ADDR_W-1:0] m_ipc;

    instruction_fetch #(.ADDR_W(ADDR_W), .RESET_PC(10'h000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_wr(imem_wr),
        .imem_data(imem_data), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_en(branch_en), .branch_target(branch_target)
    );

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr];

    function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
        return {mem[a], mem[a + 10'd1], mem[a + 10'd2], mem[a + 10'd3]};
    endfunction

    function automatic logic [ADDR_W-1:0] m_addr();
        return m_valid ? m_pc : m_pc + ADDR_W'(m_got);
    endfunction

    // One clock edge: the model consumes the inputs that the DUT sees on that edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            m_pc = 10'h000; m_got = 0; m_valid = 1'b0; m_instr = '0; m_ipc = '0;
        end else if (branch_en) begin
            m_pc = {branch_target[ADDR_W-1:2], 2'b00}; m_got = 0; m_valid = 1'b0;
        end else if (m_valid) begin
            if (instr_ready) begin
                m_pc = m_pc + 10'd4; m_got = 0; m_valid = 1'b0;
            end
        end else begin
            m_got++;
            if (m_got == 4) begin
                m_valid = 1'b1; m_instr = word_at(m_pc); m_ipc = m_pc;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_ready = 1'b1; branch_en = 1'b0; branch_target = '0;
        step(); step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
        checks++; if (instr_pc !== 10'h000) begin errors++; $display("FAIL reset_instr_pc got %h want 000", instr_pc); end
        checks++; if (imem_addr !== 10'h000) begin errors++; $display("FAIL reset_addr got %h want 000", imem_addr); end
        checks++; if (imem_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %0b want 0", imem_wr); end
    endtask

    task automatic test_first_word();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (imem_addr !== ADDR_W'(k)) begin errors++; $display("FAIL first_addr[%0d] got %h want %h", k, imem_addr, k); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL first_early_valid[%0d] got %0b want 0", k, instr_valid); end
            step();
        end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %0b want 1", instr_valid); end
        checks++; if (instr !== 32'h8C220004) begin errors++; $display("FAIL first_instr got %h want 8c220004", instr); end
        checks++; if (instr_pc !== 10'h000) begin errors++; $display("FAIL first_pc got %h want 000", instr_pc); end
    endtask

    task automatic test_back_to_back();
        instr_ready = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            for (int c = 1; c <= 5; c++) begin
                step();
                checks++; if (imem_wr !== 1'b0) begin errors++; $display("FAIL b2b_wr got %0b want 0", imem_wr); end
                checks++; if (instr_valid !== (c == 5)) begin errors++; $display("FAIL b2b_valid n%0d c%0d got %0b want %0b", n, c, instr_valid, c == 5); end
            end
            checks++; if (instr_pc !== ADDR_W'(4 * n)) begin errors++; $display("FAIL b2b_pc got %h want %h", instr_pc, 4 * n); end
            checks++; if (instr !== word_at(ADDR_W'(4 * n))) begin errors++; $display("FAIL b2b_instr got %h want %h", instr, word_at(ADDR_W'(4 * n))); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        held = instr;
        instr_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++; if (instr !== held || instr_pc !== 10'h00C || instr_valid !== 1'b1)
                begin errors++; $display("FAIL bp_hold got %h/%h/%0b want %h/00c/1", instr, instr_pc, instr_valid, held); end
            checks++; if (imem_addr !== 10'h00C) begin errors++; $display("FAIL bp_addr got %h want 00c", imem_addr); end
        end
        instr_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (imem_addr !== ADDR_W'(16 + c) || instr_valid !== 1'b0)
                begin errors++; $display("FAIL bp_refetch got %h/%0b want %h/0", imem_addr, instr_valid, 16 + c); end
        end
        step();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'h010)
            begin errors++; $display("FAIL bp_next got %0b/%h want 1/010", instr_valid, instr_pc); end
    endtask

    task automatic test_branch();
        instr_ready = 1'b1;
        step(); step(); step();
        branch_en = 1'b1; branch_target = 10'h107;
        step();
        branch_en = 1'b0;
        checks++; if (imem_addr !== 10'h104 || instr_valid !== 1'b0)
            begin errors++; $display("FAIL br_addr got %h/%0b want 104/0", imem_addr, instr_valid); end
        step(); step(); step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL br_early got %0b want 0", instr_valid); end
        step();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'h104)
            begin errors++; $display("FAIL br_word got %0b/%h want 1/104", instr_valid, instr_pc); end
        checks++; if (instr !== word_at(10'h104)) begin errors++; $display("FAIL br_instr got %h want %h", instr, word_at(10'h104)); end
    endtask

    task automatic test_branch_handshake();
        instr_ready = 1'b1; branch_en = 1'b1; branch_target = 10'h200;
        step();
        branch_en = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 10'h200)
            begin errors++; $display("FAIL brhs_addr got %0b/%h want 0/200", instr_valid, imem_addr); end
        repeat (4) step();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'h200)
            begin errors++; $display("FAIL brhs_word got %0b/%h want 1/200", instr_valid, instr_pc); end
    endtask

    task automatic test_branch_at_last_byte();
        instr_ready = 1'b1;
        repeat (4) step();
        branch_en = 1'b1; branch_target = 10'h040;
        step();
        branch_en = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 10'h040)
            begin errors++; $display("FAIL brlast got %0b/%h want 0/040", instr_valid, imem_addr); end
        repeat (4) step();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'h040)
            begin errors++; $display("FAIL brlast_word got %0b/%h want 1/040", instr_valid, instr_pc); end
    endtask

    task automatic test_reset_midfetch();
        instr_ready = 1'b1;
        step(); step(); step();
        rst_n = 1'b0;
        step();
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 10'h000 || instr !== 32'h0)
            begin errors++; $display("FAIL rstmid got %0b/%h/%h want 0/000/0", instr_valid, imem_addr, instr); end
        rst_n = 1'b1;
        repeat (4) step();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'h000 || instr !== 32'h8C220004)
            begin errors++; $display("FAIL rstmid_word got %0b/%h/%h want 1/000/8c220004", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_wrap();
        branch_en = 1'b1; branch_target = 10'h3FF;
        step();
        branch_en = 1'b0; instr_ready = 1'b1;
        repeat (4) step();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'h3FC || instr !== word_at(10'h3FC))
            begin errors++; $display("FAIL wrap_last got %0b/%h/%h want 1/3fc/%h", instr_valid, instr_pc, instr, word_at(10'h3FC)); end
        step();
        checks++; if (imem_addr !== 10'h000) begin errors++; $display("FAIL wrap_addr got %h want 000", imem_addr); end
        repeat (4) step();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'h000)
            begin errors++; $display("FAIL wrap_next got %0b/%h want 1/000", instr_valid, instr_pc); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst_n         = ($urandom_range(0, 59) != 0);
            instr_ready   = ($urandom_range(0, 1) == 1);
            branch_en     = ($urandom_range(0, 11) == 0);
            branch_target = ADDR_W'($urandom);
            step();
            checks++; if (imem_addr !== m_addr() || instr_valid !== m_valid || instr_pc !== m_ipc ||
                          instr !== m_instr || imem_wr !== 1'b0)
                begin errors++; $display("FAIL rand c%0d got a=%h v=%0b pc=%h i=%h want a=%h v=%0b pc=%h i=%h",
                    c, imem_addr, instr_valid, instr_pc, instr, m_addr(), m_valid, m_ipc, m_instr); end
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'($urandom);
        mem[0] = 8'h8C; mem[1] = 8'h22; mem[2] = 8'h00; mem[3] = 8'h04;
        m_pc = '0; m_got = 0; m_valid = 1'b0; m_instr = '0; m_ipc = '0;
        test_reset();
        test_first_word();
        test_back_to_back();
        test_backpressure();
        test_branch();
        test_branch_handshake();
        test_branch_at_last_byte();
        test_reset_midfetch();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
